// File: rtl/morse_pkg.sv
// Shared constants for the Morse key timer: FSM state encoding
// and default tick thresholds for press and gap classification.
package morse_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int DEF_DASH_TICKS       = 3;
    localparam int DEF_MAX_PRESS_TICKS  = 15;
    localparam int DEF_LETTER_GAP_TICKS = 3;
    localparam int DEF_WORD_GAP_TICKS   = 7;

endpackage

// File: rtl/morse_key_timer_if.sv
// Event bundle from the key timer to the game-control FSM.
// master drives key_level and the one-cycle event pulses; slave observes.
interface morse_key_timer_if;

    logic key_level;
    logic sym_valid;
    logic sym_is_dash;
    logic letter_end;
    logic word_end;
    logic too_long;

    modport master (
        output key_level, sym_valid, sym_is_dash,
        output letter_end, word_end, too_long
    );

    modport slave (
        input key_level, sym_valid, sym_is_dash,
        input letter_end, word_end, too_long
    );

endinterface

// File: rtl/morse_debounce.sv
// Two-flop synchroniser plus debounce of the raw key.
// Ports: clk, rst (sync, active-low), key_in -> key_level, rise, fall.
module morse_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic rise,
    output logic fall
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        cnt_d   = '0;
        // A change must persist for DEBOUNCE_CYCLES samples in a row.
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) level_d = sync2_q;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;
    assign rise      = level_q & ~prev_q;
    assign fall      = ~level_q & prev_q;

endmodule

// File: rtl/morse_key_timer.sv
// Measures key press and release lengths in 100 ms ticks and emits
// registered one-cycle dot/dash, letter-end, word-end and too-long events.
// Ports: clk, rst (sync, active-low), tick_100ms, enable, key_in, evt (master).
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int CNT_W            = 4,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int DASH_TICKS       = DEF_DASH_TICKS,
    parameter int MAX_PRESS_TICKS  = DEF_MAX_PRESS_TICKS,
    parameter int LETTER_GAP_TICKS = DEF_LETTER_GAP_TICKS,
    parameter int WORD_GAP_TICKS   = DEF_WORD_GAP_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_100ms,
    input  logic enable,
    input  logic key_in,
    morse_key_timer_if.master evt
);

    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PRESS_TICKS);
    localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP_TICKS);

    logic key_level, rise, fall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] gap_inc;
    logic             fired_q, fired_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_is_dash_q, sym_is_dash_d;
    logic             letter_end_q, letter_end_d;
    logic             word_end_q, word_end_d;
    logic             too_long_q, too_long_d;

    morse_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_level(key_level),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        fired_d       = fired_q;
        sym_valid_d   = 1'b0;
        sym_is_dash_d = 1'b0;
        letter_end_d  = 1'b0;
        word_end_d    = 1'b0;
        too_long_d    = 1'b0;
        gap_inc       = count_q + 1'b1;
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
            fired_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    // A fall here (key held across enable) is ignored.
                    if (rise) state_d = ST_PRESS;
                end
                ST_PRESS: begin
                    // Edges take priority; a coincident tick is dropped.
                    if (fall) begin
                        if (count_q >= MAX_C) begin
                            too_long_d = 1'b1;
                        end else begin
                            sym_valid_d   = 1'b1;
                            sym_is_dash_d = (count_q >= DASH_C);
                        end
                        state_d = ST_GAP;
                        count_d = '0;
                        fired_d = 1'b0;
                    end else if (tick_100ms && count_q < MAX_C) begin
                        count_d = count_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (rise) begin
                        state_d = ST_PRESS;
                        count_d = '0;
                    end else if (tick_100ms) begin
                        count_d = gap_inc;
                        if (gap_inc == LETTER_C && !fired_q) begin
                            letter_end_d = 1'b1;
                            fired_d      = 1'b1;
                        end
                        if (gap_inc == WORD_C) begin
                            word_end_d = 1'b1;
                            state_d    = ST_IDLE;
                            count_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            fired_q       <= 1'b0;
            sym_valid_q   <= 1'b0;
            sym_is_dash_q <= 1'b0;
            letter_end_q  <= 1'b0;
            word_end_q    <= 1'b0;
            too_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            fired_q       <= fired_d;
            sym_valid_q   <= sym_valid_d;
            sym_is_dash_q <= sym_is_dash_d;
            letter_end_q  <= letter_end_d;
            word_end_q    <= word_end_d;
            too_long_q    <= too_long_d;
        end
    end

    assign evt.key_level   = key_level;
    assign evt.sym_valid   = sym_valid_q;
    assign evt.sym_is_dash = sym_is_dash_q;
    assign evt.letter_end  = letter_end_q;
    assign evt.word_end    = word_end_q;
    assign evt.too_long    = too_long_q;

endmodule

// File: tb/tb_morse_key_timer.sv
// Self-checking bench for morse_key_timer: directed scenarios plus
// random press/gap lengths scored against a tick-counting event model.
module tb_morse_key_timer;

    localparam int TP = 16;

    localparam int EV_DOT    = 1;
    localparam int EV_DASH   = 2;
    localparam int EV_LONG   = 3;
    localparam int EV_LETTER = 4;
    localparam int EV_WORD   = 5;

    logic clk = 1'b0;
    logic rst, tick_100ms, enable, key_in;
    logic rst_cmd, key_cmd, en_cmd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_ev[int];

    morse_key_timer_if evt();

    morse_key_timer dut (
        .clk       (clk),
        .rst       (rst),
        .tick_100ms(tick_100ms),
        .enable    (enable),
        .key_in    (key_in),
        .evt       (evt)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ev_vec(int code);
        // {sym_valid, sym_is_dash, letter_end, word_end, too_long}
        case (code)
            EV_DOT:    return 5'b10000;
            EV_DASH:   return 5'b11000;
            EV_LETTER: return 5'b00100;
            EV_WORD:   return 5'b00010;
            EV_LONG:   return 5'b00001;
            default:   return 5'b00000;
        endcase
    endfunction

    task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    // Cycle n = interval after the n-th rising edge; inputs for it are
    // applied here and the outputs seen are the result of edge n.
    task automatic step();
        logic [4:0] obs, exp;
        @(posedge clk);
        #1;
        cyc++;
        rst        = rst_cmd;
        key_in     = key_cmd;
        enable     = en_cmd;
        tick_100ms = (cyc % TP == 0);
        obs = {evt.sym_valid, evt.sym_is_dash & evt.sym_valid,
               evt.letter_end, evt.word_end, evt.too_long};
        exp = exp_ev.exists(cyc) ? ev_vec(exp_ev[cyc]) : 5'b0;
        chk("events", obs, exp);
    endtask

    task automatic run_until(int c);
        while (cyc < c) step();
    endtask

    // Ticks strictly between two debounced edges are the measured length.
    function automatic int ticks_between(int a, int b);
        int n = 0;
        for (int t = (a / TP + 1) * TP; t < b; t += TP) n++;
        return n;
    endfunction

    task automatic sched_press(int d0, int d1);
        int n = ticks_between(d0, d1);
        if (n >= 15)     exp_ev[d1 + 1] = EV_LONG;
        else if (n >= 3) exp_ev[d1 + 1] = EV_DASH;
        else             exp_ev[d1 + 1] = EV_DOT;
    endtask

    task automatic sched_gap(int d1, int d2);
        int j = 0;
        for (int t = (d1 / TP + 1) * TP; t < d2; t += TP) begin
            j++;
            if (j == 3) exp_ev[t + 1] = EV_LETTER;
            if (j == 7) begin
                exp_ev[t + 1] = EV_WORD;
                break;
            end
        end
    endtask

    // Press for hold cycles, release for gap cycles. A clean key change
    // shows on key_level 6 cycles after it is applied.
    task automatic seq(int hold, int gap, int phase, bit sy, bit gp);
        int k0, k1;
        if (phase >= 0)
            while ((cyc + 1) % TP != phase) step();
        k0 = cyc + 1;
        k1 = k0 + hold;
        if (sy) sched_press(k0 + 6, k1 + 6);
        if (gp) sched_gap(k1 + 6, k1 + gap + 6);
        key_cmd = 1'b1;
        run_until(k1 - 1);
        if (hold >= 7) chk("key_level_held", {4'b0, evt.key_level}, 5'd1);
        key_cmd = 1'b0;
        run_until(k1 + gap - 1);
        if (gap >= 7) chk("key_level_rel", {4'b0, evt.key_level}, 5'd0);
    endtask

    initial begin
        rst = 1'b0; key_in = 1'b1; enable = 1'b1; tick_100ms = 1'b0;
        rst_cmd = 1'b0; key_cmd = 1'b1; en_cmd = 1'b1;

        // Reset with key held and enabled.
        repeat (5) step();
        chk("reset_level", {4'b0, evt.key_level}, 5'd0);
        rst_cmd = 1'b1;
        key_cmd = 1'b0;
        repeat (6) step();
        chk("post_reset_level", {4'b0, evt.key_level}, 5'd0);
        repeat (2 * TP) step();

        // Dot, then full gap to word end.
        seq(2 * TP, 8 * TP, 1, 1'b1, 1'b1);

        // Dash at exact threshold, short gap, then a dot in same letter.
        seq(3 * TP, 2 * TP, 1, 1'b1, 1'b1);
        seq(2 * TP, 8 * TP, -1, 1'b1, 1'b1);

        // Longest dash, exact error boundary, saturated error press.
        seq(14 * TP, 8 * TP, 1, 1'b1, 1'b1);
        seq(15 * TP, 8 * TP, 1, 1'b1, 1'b1);
        seq(20 * TP, 8 * TP, 1, 1'b1, 1'b1);

        // Zero-tick press is a dot.
        seq(4, 8 * TP, 1, 1'b1, 1'b1);

        // Bouncing key never reaches key_level.
        for (int i = 0; i < 20; i++) begin
            key_cmd = ((i / 2) % 2 == 0);
            step();
            chk("bounce_level", {4'b0, evt.key_level}, 5'd0);
        end
        key_cmd = 1'b0;
        repeat (10) step();
        chk("bounce_after", {4'b0, evt.key_level}, 5'd0);

        // Rise lands on a tick cycle: that tick is dropped, 2 remain.
        seq(2 * TP + 4, 8 * TP, TP - 6, 1'b1, 1'b1);

        // Disable after gap tick 2, key pressed while disabled.
        seq(2 * TP, 2 * TP + 2, 1, 1'b1, 1'b0);
        en_cmd = 1'b0;
        repeat (10 * TP) step();
        key_cmd = 1'b1;
        repeat (TP) step();
        en_cmd = 1'b1;
        repeat (3 * TP) step();
        chk("held_on_enable", {4'b0, evt.key_level}, 5'd1);
        key_cmd = 1'b0;
        repeat (9 * TP) step();
        seq(TP, 8 * TP, 1, 1'b1, 1'b1);

        // Reset mid-press aborts without events.
        while ((cyc + 1) % TP != 1) step();
        key_cmd = 1'b1;
        repeat (3 * TP) step();
        rst_cmd = 1'b0;
        repeat (3) step();
        chk("midpress_reset", {4'b0, evt.key_level}, 5'd0);
        key_cmd = 1'b0;
        rst_cmd = 1'b1;
        repeat (10 * TP) step();

        // Random press/gap lengths, back to back.
        for (int i = 0; i < 14; i++) begin
            int h, g;
            h = $urandom_range(4, 17 * TP);
            g = $urandom_range(4, 9 * TP);
            seq(h, g, -1, 1'b1, 1'b1);
        end
        seq(TP, 8 * TP, -1, 1'b1, 1'b1);
        repeat (2 * TP) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Downstream consumer of the 100 ms tick and timeout chain.
- Conditions the raw Morse key (synchronise and debounce), then measures each press length and each release gap in 100 ms ticks.
- Emits one-cycle dot/dash symbol events plus letter-end and word-end gap events to the game-control FSM.
- Holds no letter decoding; it is timing classification only.

Parameters:
- CNT_W, 4: width of the press/gap tick counter.
- DEBOUNCE_CYCLES, 4: consecutive clk cycles a synchronised key change must hold before it is accepted (set large on hardware, 4 in simulation).
- DASH_TICKS, 3: press length in ticks at or above which the press is a dash; below it is a dot.
- MAX_PRESS_TICKS, 15: press length at which the press is an error; must satisfy DASH_TICKS < MAX_PRESS_TICKS <= 2^CNT_W-1.
- LETTER_GAP_TICKS, 3: release length that closes a letter.
- WORD_GAP_TICKS, 7: release length that closes a word; must satisfy LETTER_GAP_TICKS < WORD_GAP_TICKS <= 2^CNT_W-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low.
- tick_100ms, input, 1: single-cycle pulse every 100 ms.
- enable, input, 1: high while the game accepts keying.
- key_in, input, 1: raw asynchronous key, high = pressed.
- key_level, output, 1: debounced key level.
- sym_valid, output, 1: single-cycle pulse, one symbol completed.
- sym_is_dash, output, 1: symbol type, qualified by sym_valid (1 = dash, 0 = dot).
- letter_end, output, 1: single-cycle pulse, letter gap reached.
- word_end, output, 1: single-cycle pulse, word gap reached.
- too_long, output, 1: single-cycle pulse, press rejected for exceeding MAX_PRESS_TICKS.

Behaviour:
Reset:
- On rst=0 at a clk edge, every output is 0.
- Synchroniser flops, debounce counter and tick counter are cleared; FSM goes to IDLE.

Conditioning:
- key_in passes through a 2-flop synchroniser to give key_sync.
- If key_sync differs from key_level, the debounce counter increments each clk.
- When the counter reaches DEBOUNCE_CYCLES-1 with key_sync still differing, key_level takes key_sync and the counter clears.
- Any cycle with key_sync equal to key_level clears the counter.
- Latency from key_in change to key_level change is 2 + DEBOUNCE_CYCLES clk.
- Edge detect compares key_level with its previous value and gives rise and fall, one cycle each.

FSM, count is CNT_W bits:
- IDLE: count is 0. A rise moves to PRESS with count=0.
- PRESS:
  - Each tick increments count, saturating at MAX_PRESS_TICKS.
  - On a fall, in the next cycle:
    - if count >= MAX_PRESS_TICKS, too_long=1 and sym_valid stays 0;
    - else sym_valid=1 and sym_is_dash=(count >= DASH_TICKS).
  - After the fall, go to GAP with count=0 and letter_fired=0.
- GAP:
  - Each tick increments count.
  - When count becomes LETTER_GAP_TICKS and letter_fired=0, letter_end=1 for one cycle and letter_fired=1.
  - When count becomes WORD_GAP_TICKS, word_end=1 for one cycle and the FSM goes to IDLE.
  - A rise moves to PRESS with count=0; the next symbol joins the current letter unless letter_end already fired.
- An error press (too_long) still enters GAP, so gap events follow normally.

Simultaneous events and boundaries:
- A tick in the same cycle as a rise or fall is dropped: count resets to 0 and the edge wins.
- A press of 0 ticks (released before any tick) is a dot.
- A press of exactly DASH_TICKS is a dash.
- A press of exactly MAX_PRESS_TICKS gives too_long.
- count never wraps: it saturates in PRESS and leaves GAP at WORD_GAP_TICKS.

enable:
- enable=0 forces IDLE with count=0 and suppresses all event outputs.
- key_level conditioning keeps running.
- On enable rising while key_level=1, no press is started; the FSM waits for the next rise.
- Reset asserted mid-press or mid-gap aborts with no event emitted.

Output timing:
- All event outputs are registered, mutually exclusive within a cycle, and never high for two consecutive cycles.

Decomposition:
- Shared package (morse_pkg):
  - FSM state encoding: IDLE, PRESS, GAP.
  - Default tick constants: DASH_TICKS, MAX_PRESS_TICKS, LETTER_GAP_TICKS, WORD_GAP_TICKS.
- Sub-module morse_debounce: synchroniser, debounce counter, key_level, rise and fall outputs, parameter DEBOUNCE_CYCLES.
- Top level holds the FSM, the tick counter and event registers.

Test Plan:
1. Reset while key_in=1 and enable=1 → all outputs 0; after release, key_level is 0 within 6 clk; no events.
2. Dot: press held 2 ticks, then released for 8 ticks → sym_valid=1 with sym_is_dash=0 on the cycle after the fall; letter_end at the 3rd gap tick; word_end at the 7th; FSM back in IDLE.
3. Dash boundary: press held exactly 3 ticks → sym_is_dash=1; a second press held 2 ticks, started after 2 gap ticks → dot, and no letter_end between the two symbols.
4. Error press: held 20 ticks → count saturates at 15; on release too_long=1 and sym_valid=0; gap events still follow.
5. Bounce and coincidence:
   - key_in toggles every 2 clk for 20 clk → key_level does not change.
   - A tick in the same cycle as the debounced rise → next press length counts from 0 (2 later ticks give a dot).
6. Disable mid-gap: enable=0 at gap tick 2 → no letter_end or word_end; re-enable with the key held → no event until release plus a new press.
